// File: rtl/sar_adc_if.sv
// Handshake and analog-front-end signals between the SAR controller and its environment.
// The controller takes the slave view; the test chip top level or a testbench drives the master side.
interface sar_adc_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cont;
  logic             abort;
  logic             comp_in;
  logic             sample_en;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, cont, abort, comp_in,
    input  sample_en, dac_code, busy, done, result
  );

  modport slave (
    input  start, cont, abort, comp_in,
    output sample_en, dac_code, busy, done, result
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives track/hold and the capacitive DAC code,
// resolves one bit per SETTLE_CYCLES window from the synchronized comparator output.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input logic      clk,
  input logic      rst_n,
  sar_adc_if.slave bus
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             sync1_q, comp_s;

  logic [WIDTH-1:0] decided;
  logic [WIDTH-1:0] next_trial;

  // Comparator output is asynchronous to clk; only the second flop is trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      comp_s  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q <= bus.comp_in;
      comp_s  <= sync1_q;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    code_d   = code_q;
    result_d = result_q;
    done_d   = 1'b0;
    sample_d = sample_q;
    busy_d   = busy_q;

    // Current trial bit resolved by the comparator, and the trial for the next bit down.
    decided         = code_q;
    decided[idx_q]  = comp_s;
    next_trial      = decided;
    next_trial[idx_q - IDX_W'(1)] = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = SAMPLE;
          cnt_d    = '0;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          code_d   = '0;
        end
      end

      SAMPLE: begin
        if (bus.abort) begin
          state_d  = IDLE;
          cnt_d    = '0;
          sample_d = 1'b0;
          busy_d   = 1'b0;
          code_d   = '0;
        end else if (cnt_q == SAMPLE_LAST) begin
          state_d  = CONVERT;
          cnt_d    = '0;
          sample_d = 1'b0;
          idx_d    = MSB_IDX;
          code_d   = MSB_CODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CONVERT: begin
        if (bus.abort) begin
          state_d  = IDLE;
          cnt_d    = '0;
          sample_d = 1'b0;
          busy_d   = 1'b0;
          code_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            result_d = decided;
            done_d   = 1'b1;
            code_d   = '0;
            if (bus.cont) begin
              state_d  = SAMPLE;
              sample_d = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            code_d = next_trial;
            idx_d  = idx_q - IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        sample_d = 1'b0;
        busy_d   = 1'b0;
        code_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      result_q <= result_d;
      done_q   <= done_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.sample_en = sample_q;
  assign bus.dac_code  = code_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;

endmodule
